// File: rtl/avs_reg_bank.sv
// Avalon-MM slave register bank: R/W control words, live status, sticky W1C events and command pulses.
// Optional build macro AVS_REG_BANK_IRQ_EN adds the IRQ_MASK register and the irq output.
module avs_reg_bank #(
  parameter int DATA_W   = 32,
  parameter int NUM_CTRL = 4,
  parameter int ADDR_W   = 4,
  parameter int EVT_W    = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         chipselect,
  input  logic [ADDR_W-1:0]            address,
  input  logic                         write,
  input  logic [DATA_W-1:0]            writedata,
  input  logic [DATA_W/8-1:0]          byteenable,
  input  logic                         read,
  output logic [DATA_W-1:0]            readdata,
  output logic                         readdatavalid,
  output logic [NUM_CTRL*DATA_W-1:0]   ctrl_out,
  input  logic [EVT_W-1:0]             status_in,
  input  logic [EVT_W-1:0]             event_in,
  output logic [DATA_W-1:0]            cmd_pulse,
  output logic                         irq
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [ADDR_W-1:0] STATUS_A = ADDR_W'(NUM_CTRL);
  localparam logic [ADDR_W-1:0] EVENT_A  = ADDR_W'(NUM_CTRL + 1);
  localparam logic [ADDR_W-1:0] MASK_A   = ADDR_W'(NUM_CTRL + 2);
  localparam logic [ADDR_W-1:0] CMD_A    = ADDR_W'(NUM_CTRL + 3);

  function automatic logic [DATA_W-1:0] lane_mask(input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < BE_W; i++) begin
      m[i*8 +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

  logic [DATA_W-1:0] ctrl_r [NUM_CTRL];
  logic [EVT_W-1:0]  status_r;
  logic [EVT_W-1:0]  event_r;
  logic [EVT_W-1:0]  event_prev_r;
  logic [EVT_W-1:0]  mask_s;
  logic [DATA_W-1:0] readdata_r;
  logic              readdatavalid_r;
  logic [DATA_W-1:0] cmd_r;
  logic              irq_r;

  logic              wr_s;
  logic              rd_s;
  logic [DATA_W-1:0] wmask_s;
  logic [EVT_W-1:0]  evt_clr_s;
  logic [EVT_W-1:0]  evt_rise_s;
  logic [DATA_W-1:0] ctrl_sel_s;
  logic [DATA_W-1:0] rdata_s;

  // A simultaneous read and write is treated as a write only.
  assign wr_s       = chipselect & write;
  assign rd_s       = chipselect & read & ~write;
  assign wmask_s    = lane_mask(byteenable);
  assign evt_rise_s = event_in & ~event_prev_r;

  // Control register storage with per-lane write enables.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_CTRL; k++) begin
        ctrl_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CTRL; k++) begin
        if (wr_s && (address == ADDR_W'(k))) begin
          ctrl_r[k] <= (ctrl_r[k] & ~wmask_s) | (writedata & wmask_s);
        end
      end
    end
  end

  // Flatten the control array onto the core-facing bus.
  always_comb begin
    ctrl_out = '0;
    for (int k = 0; k < NUM_CTRL; k++) begin
      ctrl_out[k*DATA_W +: DATA_W] = ctrl_r[k];
    end
  end

  // W1C clear bits, gated by the lane enable covering each bit.
  always_comb begin
    evt_clr_s = '0;
    if (wr_s && (address == EVENT_A)) begin
      evt_clr_s = writedata[EVT_W-1:0] & wmask_s[EVT_W-1:0];
    end else begin
      evt_clr_s = '0;
    end
  end

  // Status sample, edge detector and sticky event capture (a new edge beats a clear).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      status_r     <= '0;
      event_prev_r <= '0;
      event_r      <= '0;
    end else begin
      status_r     <= status_in;
      event_prev_r <= event_in;
      event_r      <= (event_r & ~evt_clr_s) | evt_rise_s;
    end
  end

`ifdef AVS_REG_BANK_IRQ_EN
  logic [EVT_W-1:0] mask_r;

  // Interrupt mask register with per-lane write enables.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mask_r <= '0;
    end else if (wr_s && (address == MASK_A)) begin
      mask_r <= (mask_r & ~wmask_s[EVT_W-1:0]) | (writedata[EVT_W-1:0] & wmask_s[EVT_W-1:0]);
    end else begin
      mask_r <= mask_r;
    end
  end

  assign mask_s = mask_r;
`else
  assign mask_s = '0;
`endif

  // Select the addressed control word.
  always_comb begin
    ctrl_sel_s = '0;
    for (int k = 0; k < NUM_CTRL; k++) begin
      ctrl_sel_s = (address == ADDR_W'(k)) ? ctrl_r[k] : ctrl_sel_s;
    end
  end

  // Read data mux; CMD and unmapped addresses read as zero.
  always_comb begin
    rdata_s = '0;
    if (address == STATUS_A) begin
      rdata_s = DATA_W'(status_r);
    end else if (address == EVENT_A) begin
      rdata_s = DATA_W'(event_r);
    end else if (address == MASK_A) begin
      rdata_s = DATA_W'(mask_s);
    end else if (address < STATUS_A) begin
      rdata_s = ctrl_sel_s;
    end else begin
      rdata_s = '0;
    end
  end

  // Registered read response, command strobes and interrupt.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      readdata_r      <= '0;
      readdatavalid_r <= 1'b0;
      cmd_r           <= '0;
      irq_r           <= 1'b0;
    end else begin
      readdatavalid_r <= rd_s;
      if (rd_s) begin
        readdata_r <= rdata_s;
      end
      if (wr_s && (address == CMD_A)) begin
        cmd_r <= writedata & wmask_s;
      end else begin
        cmd_r <= '0;
      end
      irq_r <= |(event_r & mask_s);
    end
  end

  assign readdata      = readdata_r;
  assign readdatavalid = readdatavalid_r;
  assign cmd_pulse     = cmd_r;
  assign irq           = irq_r;

endmodule

// File: tb/tb_avs_reg_bank.sv
// Scoreboard bench for avs_reg_bank: directed test-plan sequences plus random traffic against a reference model.
module tb_avs_reg_bank;
  localparam int DATA_W = 32;
  localparam int NUM_CTRL = 4;
  localparam int ADDR_W = 4;
  localparam int EVT_W = 8;
`ifdef AVS_REG_BANK_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n, chipselect, write, read;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0] readdata;
  logic readdatavalid;
  logic [NUM_CTRL*DATA_W-1:0] ctrl_out;
  logic [EVT_W-1:0] status_in, event_in;
  logic [DATA_W-1:0] cmd_pulse;
  logic irq;

  avs_reg_bank #(.DATA_W(DATA_W), .NUM_CTRL(NUM_CTRL), .ADDR_W(ADDR_W), .EVT_W(EVT_W)) dut (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
    .write(write), .writedata(writedata), .byteenable(byteenable), .read(read),
    .readdata(readdata), .readdatavalid(readdatavalid), .ctrl_out(ctrl_out),
    .status_in(status_in), .event_in(event_in), .cmd_pulse(cmd_pulse), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  // reference model state (values visible after the most recent edge)
  logic [DATA_W-1:0] m_ctrl [NUM_CTRL];
  logic [EVT_W-1:0] m_event = '0, m_mask = '0, m_status = '0, m_prev = '0;
  logic [DATA_W-1:0] exp_cmd = '0;
  logic exp_irq = 1'b0;
  logic [DATA_W-1:0] rd_q [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] model_read(input int a);
    if (a < NUM_CTRL) return m_ctrl[a];
    case (a - NUM_CTRL)
      0: return DATA_W'(m_status);
      1: return DATA_W'(m_event);
      2: return DATA_W'(m_mask);
      default: return '0;
    endcase
  endfunction

  // Apply the effect of the coming clock edge to the model, then advance past it.
  task automatic cyc();
    logic [DATA_W-1:0] bm;
    logic [EVT_W-1:0] clr;
    logic [EVT_W-1:0] old_ev, old_mk;
    int a;
    a = int'(address);
    for (int i = 0; i < DATA_W/8; i++) bm[i*8 +: 8] = byteenable[i] ? 8'hFF : 8'h00;
    if (!reset_n) begin
      for (int k = 0; k < NUM_CTRL; k++) m_ctrl[k] = '0;
      m_event = '0; m_mask = '0; m_status = '0; m_prev = '0;
      exp_cmd = '0; exp_irq = 1'b0;
    end else begin
      old_ev = m_event; old_mk = m_mask; clr = '0; exp_cmd = '0;
      if (chipselect && read && !write) rd_q.push_back(model_read(a));
      if (chipselect && write) begin
        if (a < NUM_CTRL) m_ctrl[a] = (m_ctrl[a] & ~bm) | (writedata & bm);
        else if (a == NUM_CTRL + 1) clr = writedata[EVT_W-1:0] & bm[EVT_W-1:0];
        else if (a == NUM_CTRL + 2 && IRQ_EN) m_mask = (m_mask & ~bm[EVT_W-1:0]) | (writedata[EVT_W-1:0] & bm[EVT_W-1:0]);
        else if (a == NUM_CTRL + 3) exp_cmd = writedata & bm;
      end
      m_event = (old_ev & ~clr) | (event_in & ~m_prev);
      m_prev = event_in;
      m_status = status_in;
      exp_irq = IRQ_EN ? |(old_ev & old_mk) : 1'b0;
    end
    @(negedge clk);
    #1;
  endtask

  // Monitor: compares outputs against the model and pops the read scoreboard.
  initial begin
    logic [DATA_W-1:0] e;
    logic [NUM_CTRL*DATA_W-1:0] ec;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        for (int k = 0; k < NUM_CTRL; k++) ec[k*DATA_W +: DATA_W] = m_ctrl[k];
        check("ctrl_out", 128'(ctrl_out), 128'(ec));
        check("cmd_pulse", 128'(cmd_pulse), 128'(exp_cmd));
        check("irq", 128'(irq), 128'(exp_irq));
        if (readdatavalid === 1'b1) begin
          if (rd_q.size() == 0) check("unexpected_readdatavalid", 128'(1), 128'(0));
          else begin
            e = rd_q.pop_front();
            check("readdata", 128'(readdata), 128'(e));
          end
        end else if (rd_q.size() != 0) begin
          void'(rd_q.pop_front());
          check("missing_readdatavalid", 128'(readdatavalid), 128'(1));
        end
      end
    end
  end

  task automatic set_bus(input logic c, input logic w, input logic r, input int a,
                         input logic [DATA_W-1:0] d, input logic [3:0] be);
    chipselect = c; write = w; read = r; address = ADDR_W'(a); writedata = d; byteenable = be;
  endtask
  task automatic wr(input int a, input logic [DATA_W-1:0] d, input logic [3:0] be);
    set_bus(1'b1, 1'b1, 1'b0, a, d, be); cyc();
  endtask
  task automatic rd(input int a);
    set_bus(1'b1, 1'b0, 1'b1, a, '0, 4'hF); cyc();
  endtask
  task automatic idle();
    set_bus(1'b0, 1'b0, 1'b0, 0, '0, 4'h0); cyc();
  endtask

  initial begin
    for (int k = 0; k < NUM_CTRL; k++) m_ctrl[k] = '0;
    reset_n = 1'b0; status_in = '0; event_in = '0;
    set_bus(1'b1, 1'b1, 1'b1, 0, 32'hFFFF_FFFF, 4'hF);
    @(negedge clk); #1;
    // reset held with bus traffic active
    cyc(); mon_en = 1'b1; cyc(); cyc();
    check("rst_ctrl_out", 128'(ctrl_out), 128'(0));
    check("rst_readdata", 128'(readdata), 128'(0));
    check("rst_rdv", 128'(readdatavalid), 128'(0));
    check("rst_cmd", 128'(cmd_pulse), 128'(0));
    check("rst_irq", 128'(irq), 128'(0));
    reset_n = 1'b1;
    rd(0);
    check("ctrl0_after_rst", 128'(readdata), 128'(0));
    check("ctrl0_rdv", 128'(readdatavalid), 128'(1));

    // byte-enabled write
    wr(1, 32'h1122_3344, 4'hF);
    wr(1, 32'hAABB_CCDD, 4'b0011);
    check("ctrl1_slice", 128'(ctrl_out[63:32]), 128'(32'h1122_CCDD));
    rd(1);
    check("ctrl1_read", 128'(readdata), 128'(32'h1122_CCDD));

    // event capture, set-beats-clear, clear
    if (IRQ_EN) wr(NUM_CTRL + 2, 32'h4, 4'hF);
    event_in = 8'h04; idle();
    check("irq_edge0", 128'(irq), 128'(0));
    event_in = 8'h00; idle();
    check("irq_edge1", 128'(irq), 128'(IRQ_EN));
    rd(NUM_CTRL + 1);
    check("event_set", 128'(readdata), 128'(32'h04));
    event_in = 8'h04; wr(NUM_CTRL + 1, 32'h04, 4'hF);
    event_in = 8'h00; rd(NUM_CTRL + 1);
    check("event_set_wins", 128'(readdata), 128'(32'h04));
    wr(NUM_CTRL + 1, 32'h04, 4'hF);
    check("irq_clr0", 128'(irq), 128'(IRQ_EN));
    rd(NUM_CTRL + 1);
    check("event_cleared", 128'(readdata), 128'(32'h00));
    check("irq_clr1", 128'(irq), 128'(0));
    rd(NUM_CTRL + 2);
    check("mask_read", 128'(readdata), 128'(IRQ_EN ? 32'h04 : 32'h00));

    // command pulse
    wr(NUM_CTRL + 3, 32'h8000_0001, 4'b0001);
    check("cmd_pulse_on", 128'(cmd_pulse), 128'(32'h1));
    idle();
    check("cmd_pulse_off", 128'(cmd_pulse), 128'(0));
    rd(NUM_CTRL + 3);
    check("cmd_read", 128'(readdata), 128'(0));

    // corner cases
    rd(NUM_CTRL + 4);
    check("unmapped_read", 128'(readdata), 128'(0));
    check("unmapped_rdv", 128'(readdatavalid), 128'(1));
    set_bus(1'b1, 1'b1, 1'b1, 0, 32'h5A, 4'hF); cyc();
    check("rw_ctrl0", 128'(ctrl_out[31:0]), 128'(32'h5A));
    check("rw_no_rdv", 128'(readdatavalid), 128'(0));
    status_in = 8'h3C; idle();
    rd(NUM_CTRL);
    check("status_read", 128'(readdata), 128'(32'h3C));

    // reset mid-read drops the response
    set_bus(1'b1, 1'b0, 1'b1, 0, '0, 4'hF); reset_n = 1'b0; cyc();
    check("rst_mid_rdv", 128'(readdatavalid), 128'(0));
    reset_n = 1'b1;

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      reset_n = ($urandom_range(0, 79) != 0);
      status_in = EVT_W'($urandom);
      event_in = EVT_W'($urandom & $urandom);
      set_bus(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom),
              int'($urandom_range(0, 15)), $urandom, 4'($urandom));
      cyc();
    end
    idle(); idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/avs_reg_bank.md
Name: avs_reg_bank

Overview:
- Parametrised Avalon-MM slave register bank. Next generation of the single write-only switch-register wrapper that sits in front of the vending-machine cores.
- Provides:
  - NUM_CTRL read/write control registers with byte enables.
  - A live status register.
  - Sticky event capture with write-1-to-clear.
  - A self-clearing command pulse register.
- Read responses use a fixed one-cycle latency, signalled with readdatavalid.
- Sits between the Nios/Avalon interconnect and a vendor core; ctrl_out replaces the old 18-bit SW register.

Parameters:
- DATA_W, 32: register and bus data width; must be a multiple of 8.
- NUM_CTRL, 4: number of R/W control registers (1..16).
- ADDR_W, 4: word address width; requires 2^ADDR_W >= NUM_CTRL+4.
- EVT_W, 8: width of the status and event inputs; must be <= DATA_W.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; one clock; reset is synchronous and active-low.
- chipselect  in  1  slave select.
- address  in  ADDR_W  word address.
- write  in  1  write strobe.
- writedata  in  DATA_W  write data.
- byteenable  in  DATA_W/8  byte lane enables.
- read  in  1  read strobe.
- readdata  out  DATA_W  registered read data.
- readdatavalid  out  1  read response strobe.
- ctrl_out  out  NUM_CTRL*DATA_W  control registers, CTRL[k] at bits [k*DATA_W +: DATA_W].
- status_in  in  EVT_W  live core status.
- event_in  in  EVT_W  event sources; rising edge is captured.
- cmd_pulse  out  DATA_W  one-cycle command strobes.
- irq  out  1  interrupt request.

Behaviour:
- Register map (word address):
  - 0..NUM_CTRL-1: CTRL[k], R/W.
  - NUM_CTRL: STATUS, RO. Reads the registered status_in, zero-extended.
  - NUM_CTRL+1: EVENT, R/W1C, EVT_W bits.
  - NUM_CTRL+2: IRQ_MASK, R/W, EVT_W bits.
  - NUM_CTRL+3: CMD, WO; reads 0.
  - Any other address: reads 0, writes ignored.
- Reset: all of the following go to 0 on the first rising clk edge with reset_n=0, and stay 0 while reset_n=0:
  - CTRL, EVENT, IRQ_MASK, the status sample, the event_in previous-value register.
  - readdata, readdatavalid, cmd_pulse, irq.
- Write accept: chipselect&write at a clk edge. Always zero wait states; no waitrequest port.
- CTRL/IRQ_MASK writes: byte lane i updates only when byteenable[i]=1. The new value appears on ctrl_out at the edge that accepts the write.
- EVENT capture: bit j sets at the edge where event_in[j]=1 and previous event_in[j]=0.
- EVENT clear: a write clears bit j where writedata[j]=1 and the byte lane containing j is enabled.
- EVENT set and clear in the same cycle on the same bit: set wins, bit stays 1.
- CMD write: cmd_pulse bit = writedata bit AND its lane enable, driven for exactly the one cycle after the accepting edge, then 0. Back-to-back CMD writes give back-to-back pulses.
- Read accept: chipselect&read&!write. readdata is loaded and readdatavalid=1 for exactly one cycle after the accept; latency is 1.
  - readdata holds its value until the next read response.
  - readdatavalid is 0 in all other cycles.
- read and write asserted together: the write is performed, the read is ignored, no response.
- Read of EVENT returns the pre-edge value; a capture in the same cycle is visible on the next read.
- STATUS is sampled every cycle (one register stage, no metastability chain; inputs are synchronous to clk).
- irq is registered: irq(t+1) = |(EVENT(t) & IRQ_MASK(t)).
- Reset asserted mid-transaction: any pending readdatavalid and cmd_pulse are dropped (forced 0).

Optional Feature:
- Macro: AVS_REG_BANK_IRQ_EN.
- Defined: IRQ_MASK register and irq output behave as described above.
- Undefined:
  - IRQ_MASK storage is not built; its address reads 0 and ignores writes.
  - irq is tied to 0.
  - EVENT capture and W1C are unchanged.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with read/write active -> ctrl_out=0, readdata=0, readdatavalid=0, cmd_pulse=0, irq=0; then read CTRL0 -> 0x00000000 one cycle after accept.
- Byte-enable write: CTRL1=0x11223344, then write 0xAABBCCDD with byteenable=4'b0011 -> CTRL1 reads 0x1122CCDD and ctrl_out[63:32]=0x1122CCDD.
- Event capture and clear:
  - Pulse event_in[2] -> EVENT=0x04.
  - Write EVENT 0x04 while a new event_in[2] rising edge occurs in the same cycle -> EVENT stays 0x04.
  - Second clear with no edge -> 0x00.
- IRQ: IRQ_MASK=0x04, event_in[2] edge -> irq=1 two cycles after the edge; clear EVENT -> irq=0 one cycle after the clear edge. With AVS_REG_BANK_IRQ_EN undefined, irq stays 0 and IRQ_MASK reads 0.
- CMD: write 0x80000001 to CMD with byteenable=4'b0001 -> cmd_pulse=0x00000001 for exactly 1 cycle; a CMD read returns 0.
- Read/write corner cases:
  - Read address NUM_CTRL+4 -> 0 with readdatavalid.
  - Simultaneous read&write to CTRL0 with 0x5A -> CTRL0=0x5A, no readdatavalid.
  - STATUS read with status_in=0x3C -> 0x0000003C.
